// File: rtl/game_settings_regs_pkg.sv
// Shared types and preset table for the game settings register block.
package game_pkg;

    localparam int REG_NUM    = 9;
    localparam int PRESET_NUM = 8;

    typedef enum logic [3:0] {
        BOARD_FIELDS = 4'd0,
        MINE_COUNT   = 4'd1,
        FIELD_PX     = 4'd2,
        BOARD_XPOS   = 4'd3,
        BOARD_YPOS   = 4'd4,
        BOARD_PX     = 4'd5,
        TIME_LIMIT   = 4'd6,
        LEVEL        = 4'd7,
        LOAD_COUNT   = 4'd8
    } reg_idx_e;

    typedef enum logic [1:0] {
        LVL_EASY   = 2'd0,
        LVL_MEDIUM = 2'd1,
        LVL_HARD   = 2'd2,
        LVL_RSVD   = 2'd3
    } level_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    // Rows: EASY, MEDIUM, HARD; columns follow reg_idx_e order 0..7.
    localparam logic [15:0] PRESET_TBL [3][PRESET_NUM] = '{
        '{16'd8,  16'd10, 16'd64, 16'd256, 16'd128, 16'd512, 16'd999, 16'd0},
        '{16'd12, 16'd24, 16'd48, 16'd224, 16'd96,  16'd576, 16'd999, 16'd1},
        '{16'd16, 16'd40, 16'd40, 16'd192, 16'd64,  16'd640, 16'd999, 16'd2}
    };

endpackage

// File: rtl/game_settings_regs_if.sv
// Pipelined Wishbone responder bus for the game settings registers.
interface game_settings_regs_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_stall_o;
    logic              wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_stall_o, wb_err_o
    );
endinterface

// File: rtl/game_settings_regs_preset_rom.sv
// Combinational preset lookup: (level, index) -> preset value; reserved level aliases EASY.
module settings_preset_rom
    import game_pkg::*;
(
    input  logic [1:0]  i_level,
    input  logic [2:0]  i_idx,
    output logic [15:0] o_val
);
    logic [1:0] w_lvl;

    always_comb begin
        w_lvl = (i_level == LVL_RSVD) ? LVL_EASY : i_level;
        o_val = PRESET_TBL[w_lvl][i_idx];
    end
endmodule

// File: rtl/game_settings_regs.sv
// Game settings register file behind a pipelined Wishbone responder, with preset loader.
// Optional: define WB_ERR_EN to answer invalid addresses with wb_err_o instead of an ack.
module game_settings_regs
    import game_pkg::*;
#(
    parameter int REG_NUM = game_pkg::REG_NUM,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           level,
    input  logic                 load,
    input  logic                 lock,
    output logic                 busy,
    game_settings_regs_if.slave  wb
);
    localparam int IDX_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] L_REG_NUM = IDX_W'(REG_NUM);
    localparam logic [IDX_W-1:0] L_CNT_IDX = IDX_W'(PRESET_NUM);

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_k;
    logic [1:0]        r_lvl;
    logic [DATA_W-1:0] r_regs [PRESET_NUM];
    logic [DATA_W-1:0] r_cnt;
    logic              r_ack;
    logic [DATA_W-1:0] r_dat;

    logic              w_stall, w_acc, w_valid, w_wr, w_ack_set, w_ack;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd;
    logic [15:0]       w_rom;

    settings_preset_rom u_rom (
        .i_level (r_lvl),
        .i_idx   (r_k),
        .o_val   (w_rom)
    );

    assign w_idx   = wb.wb_adr_i[ADDR_W-1:1];
    assign w_valid = !wb.wb_adr_i[0] && (w_idx < L_REG_NUM);
    assign w_acc   = wb.wb_cyc_i & wb.wb_stb_i & ~w_stall;
    assign w_wr    = w_acc & wb.wb_we_i & w_valid & ~lock & (w_idx < L_CNT_IDX);

    always_comb begin
        w_rd = '0;
        if (w_valid) begin
            if (w_idx < L_CNT_IDX)       w_rd = r_regs[w_idx[2:0]];
            else if (w_idx == L_CNT_IDX) w_rd = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (load)         w_state_nxt = ST_LOAD;
            ST_LOAD: if (r_k == 3'd7)  w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_stall = (r_state == ST_LOAD);
        busy    = w_stall;
    end

    // Bus writes cannot collide with preset writes: nothing is accepted while loading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_lvl <= LVL_EASY;
            r_cnt <= '0;
            for (int i = 0; i < PRESET_NUM; i++) r_regs[i] <= DATA_W'(PRESET_TBL[0][i]);
        end else if (r_state == ST_LOAD) begin
            r_regs[r_k] <= DATA_W'(w_rom);
            r_k         <= r_k + 3'd1;
            if (r_k == 3'd7) r_cnt <= r_cnt + 1'b1;
        end else begin
            if (load) begin
                r_lvl <= level;
                r_k   <= '0;
            end
            if (w_wr) r_regs[w_idx[2:0]] <= wb.wb_dat_i;
        end
    end

`ifdef WB_ERR_EN
    logic r_err;
    assign w_ack_set = w_acc & w_valid;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_acc & ~w_valid;
    end
    assign wb.wb_err_o = r_err & wb.wb_cyc_i;
`else
    assign w_ack_set   = w_acc;
    assign wb.wb_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_ack_set;
            r_dat <= (w_acc & ~wb.wb_we_i) ? w_rd : '0;
        end
    end

    // An abandoned cycle swallows its pending response.
    assign w_ack         = r_ack & wb.wb_cyc_i;
    assign wb.wb_ack_o   = w_ack;
    assign wb.wb_dat_o   = w_ack ? r_dat : '0;
    assign wb.wb_stall_o = w_stall;
endmodule

// File: tb/tb_game_settings_regs.sv
// Randomized self-checking bench for game_settings_regs against an array-based register model.
module tb_game_settings_regs;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] level = 2'd0;
    logic       load = 1'b0;
    logic       lock = 1'b0;
    logic       busy;

    game_settings_regs_if #(.ADDR_W(8), .DATA_W(16)) wb_if ();

    game_settings_regs #(.REG_NUM(9), .ADDR_W(8), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .level (level),
        .load  (load),
        .lock  (lock),
        .busy  (busy),
        .wb    (wb_if.slave)
    );

    always #5 clk = ~clk;

`ifdef WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int exp_regs [9];
    int pre_tbl [3][8] = '{
        '{8,  10, 64, 256, 128, 512, 999, 0},
        '{12, 24, 48, 224, 96,  576, 999, 1},
        '{16, 40, 40, 192, 64,  640, 999, 2}
    };

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) exp_regs[k] = pre_tbl[0][k];
        exp_regs[8] = 0;
    endfunction

    function automatic void model_load(int lv);
        int l;
        l = (lv == 3) ? 0 : lv;
        for (int k = 0; k < 8; k++) exp_regs[k] = pre_tbl[l][k];
        exp_regs[8] = (exp_regs[8] + 1) % 65536;
    endfunction

    function automatic bit addr_ok(int adr);
        return (adr % 2 == 0) && (adr / 2 < 9);
    endfunction

    function automatic int model_read(int adr);
        return addr_ok(adr) ? exp_regs[adr / 2] : 0;
    endfunction

    function automatic void model_write(int adr, int dat, bit lk);
        if (addr_ok(adr) && adr / 2 < 8 && !lk) exp_regs[adr / 2] = dat;
    endfunction

    task automatic bus_req(input bit we, input int adr, input int dat,
                           output bit ack, output bit err, output int rdat, output bit stl);
        @(negedge clk);
        stl = wb_if.wb_stall_o;
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = we;
        wb_if.wb_adr_i = 8'(adr);
        wb_if.wb_dat_i = 16'(dat);
        @(negedge clk);
        ack  = wb_if.wb_ack_o;
        err  = wb_if.wb_err_o;
        rdat = int'(wb_if.wb_dat_o);
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
    endtask

    // Pulses load, optionally re-strobes mid-load, and counts busy cycles (bounded).
    task automatic run_load(input int lv, input int lv2, output int cnt, output bit bad_stall);
        @(negedge clk);
        level = 2'(lv);
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cnt = 0;
        bad_stall = 1'b0;
        while (busy && cnt < 20) begin
            if (!wb_if.wb_stall_o) bad_stall = 1'b1;
            cnt++;
            if (cnt == 3) begin
                load  = 1'b1;
                level = 2'(lv2);
            end else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        bit ack, err, stl;
        int rd;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, wb_if.wb_ack_o, wb_if.wb_err_o, wb_if.wb_stall_o} !== 4'b0 || wb_if.wb_dat_o !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: busy/ack/err/stall=%b%b%b%b dat=%0h, required all 0",
                     busy, wb_if.wb_ack_o, wb_if.wb_err_o, wb_if.wb_stall_o, wb_if.wb_dat_o);
        end
        rst_n = 1'b1;
        model_reset();
        bus_req(1'b0, 2, 0, ack, err, rd, stl);
        checks++;
        if (ack !== 1'b1 || rd !== 10) begin
            failures++;
            $display("FAIL reset_read_0x02: ack=%0b dat=%0d, required ack=1 dat=10", ack, rd);
        end
    endtask

    task automatic test_load(input int lv, input int lv2);
        int cnt;
        bit bad, ack, err, stl;
        int rd;
        int adrs [3] = '{0, 2, 16};
        run_load(lv, lv2, cnt, bad);
        model_load(lv);
        checks++;
        if (cnt !== 8 || bad) begin
            failures++;
            $display("FAIL load_busy_len: busy cycles=%0d stall_drop=%0b, required 8 and 0", cnt, bad);
        end
        checks++;
        if (wb_if.wb_stall_o !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL load_idle_after: stall=%0b busy=%0b, required 0", wb_if.wb_stall_o, busy);
        end
        foreach (adrs[i]) begin
            bus_req(1'b0, adrs[i], 0, ack, err, rd, stl);
            checks++;
            if (ack !== 1'b1 || rd !== model_read(adrs[i])) begin
                failures++;
                $display("FAIL load_read_%0h: ack=%0b dat=%0d, required ack=1 dat=%0d",
                         adrs[i], ack, rd, model_read(adrs[i]));
            end
        end
    endtask

    task automatic test_burst();
        int rd;
        for (int i = 0; i <= 9; i++) begin
            @(negedge clk);
            if (i > 0) begin
                rd = int'(wb_if.wb_dat_o);
                checks++;
                if (wb_if.wb_ack_o !== 1'b1 || rd !== model_read(2 * (i - 1))) begin
                    failures++;
                    $display("FAIL burst_%0d: ack=%0b dat=%0d, required ack=1 dat=%0d",
                             i - 1, wb_if.wb_ack_o, rd, model_read(2 * (i - 1)));
                end
            end
            if (i < 9) begin
                checks++;
                if (wb_if.wb_stall_o !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_stall_%0d: stall=%0b, required 0", i, wb_if.wb_stall_o);
                end
                wb_if.wb_cyc_i = 1'b1;
                wb_if.wb_stb_i = 1'b1;
                wb_if.wb_we_i  = 1'b0;
                wb_if.wb_adr_i = 8'(2 * i);
            end else begin
                wb_if.wb_cyc_i = 1'b0;
                wb_if.wb_stb_i = 1'b0;
            end
        end
    endtask

    task automatic test_lock();
        bit ack, err, stl;
        int rd;
        lock = 1'b1;
        bus_req(1'b1, 2, 0, ack, err, rd, stl);
        model_write(2, 0, 1'b1);
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL lock_write_ack: ack=%0b, required 1", ack);
        end
        lock = 1'b0;
        bus_req(1'b0, 2, 0, ack, err, rd, stl);
        checks++;
        if (rd !== model_read(2)) begin
            failures++;
            $display("FAIL lock_readback: dat=%0d, required %0d", rd, model_read(2));
        end
        bus_req(1'b1, 16, 16'h1234, ack, err, rd, stl);
        bus_req(1'b0, 16, 0, ack, err, rd, stl);
        checks++;
        if (rd !== model_read(16)) begin
            failures++;
            $display("FAIL ro_count_write: dat=%0d, required %0d", rd, model_read(16));
        end
    endtask

    task automatic test_invalid();
        bit ack, err, stl;
        int rd;
        int adrs [4] = '{3, 18, 5, 255};
        foreach (adrs[i]) begin
            bit we;
            we = (i >= 2);
            bus_req(we, adrs[i], 16'hBEEF, ack, err, rd, stl);
            checks++;
            if (ERR_EN ? (err !== 1'b1 || ack !== 1'b0) : (ack !== 1'b1 || err !== 1'b0 || rd !== 0)) begin
                failures++;
                $display("FAIL invalid_%0h: ack=%0b err=%0b dat=%0d, required err_mode=%0b dat=0",
                         adrs[i], ack, err, rd, ERR_EN);
            end
        end
        test_burst();
    endtask

    task automatic test_load_concurrent();
        int cnt;
        int rd;
        @(negedge clk);
        level = 2'd1;
        load  = 1'b1;
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = 8'h04;
        @(negedge clk);
        load = 1'b0;
        rd = int'(wb_if.wb_dat_o);
        checks++;
        if (wb_if.wb_ack_o !== 1'b1 || rd !== model_read(4) || busy !== 1'b1) begin
            failures++;
            $display("FAIL load_concurrent_read: ack=%0b dat=%0d busy=%0b, required ack=1 dat=%0d busy=1",
                     wb_if.wb_ack_o, rd, busy, model_read(4));
        end
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        model_load(1);
        checks++;
        if (cnt !== 8) begin
            failures++;
            $display("FAIL load_concurrent_len: busy cycles=%0d, required 8", cnt);
        end
        test_burst();
    endtask

    task automatic test_cyc_drop();
        bit ack, err, stl;
        int rd, v;
        v = $urandom_range(0, 65535);
        @(negedge clk);
        wb_if.wb_cyc_i = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_we_i  = 1'b1;
        wb_if.wb_adr_i = 8'h06;
        wb_if.wb_dat_i = 16'(v);
        @(posedge clk);
        #1;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        #1;
        checks++;
        if (wb_if.wb_ack_o !== 1'b0 || wb_if.wb_dat_o !== 16'h0) begin
            failures++;
            $display("FAIL cyc_drop_ack: ack=%0b dat=%0h, required 0/0", wb_if.wb_ack_o, wb_if.wb_dat_o);
        end
        model_write(6, v, 1'b0);
        bus_req(1'b0, 6, 0, ack, err, rd, stl);
        checks++;
        if (rd !== model_read(6)) begin
            failures++;
            $display("FAIL cyc_drop_write_kept: dat=%0d, required %0d", rd, model_read(6));
        end
    endtask

    task automatic test_reset_during_load();
        @(negedge clk);
        level = 2'd2;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wb_if.wb_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: busy=%0b stall=%0b, required 0", busy, wb_if.wb_stall_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        test_burst();
    endtask

    task automatic test_random(input int n);
        bit ack, err, stl, we, valid, bad;
        int rd, adr, dat, cnt, lv;
        for (int it = 0; it < n; it++) begin
            if ($urandom_range(0, 15) == 0) begin
                lv = $urandom_range(0, 3);
                run_load(lv, $urandom_range(0, 3), cnt, bad);
                model_load(lv);
                checks++;
                if (cnt !== 8 || bad) begin
                    failures++;
                    $display("FAIL rand_load_%0d: busy cycles=%0d stall_drop=%0b, required 8/0", it, cnt, bad);
                end
            end
            lock = ($urandom_range(0, 3) == 0);
            adr  = ($urandom_range(0, 9) < 8) ? 2 * $urandom_range(0, 8) : $urandom_range(0, 255);
            we   = $urandom_range(0, 1);
            dat  = $urandom_range(0, 65535);
            valid = addr_ok(adr);
            bus_req(we, adr, dat, ack, err, rd, stl);
            checks++;
            if ((ERR_EN && !valid) ? (err !== 1'b1 || ack !== 1'b0)
                                   : (ack !== 1'b1 || err !== 1'b0 || (!we && rd !== model_read(adr)))) begin
                failures++;
                $display("FAIL rand_%0d: we=%0b adr=%0h ack=%0b err=%0b dat=%0d, required dat=%0d",
                         it, we, adr, ack, err, rd, model_read(adr));
            end
            if (we && !(ERR_EN && !valid)) model_write(adr, dat, lock);
        end
        lock = 1'b0;
        test_burst();
    endtask

    task automatic test_wrap();
        bit ack, err, stl, bad;
        int rd, cnt;
        @(negedge clk);
        force dut.r_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_cnt;
        exp_regs[8] = 65535;
        bus_req(1'b0, 16, 0, ack, err, rd, stl);
        checks++;
        if (rd !== 65535) begin
            failures++;
            $display("FAIL wrap_preset: dat=%0d, required 65535", rd);
        end
        run_load(0, 0, cnt, bad);
        model_load(0);
        bus_req(1'b0, 16, 0, ack, err, rd, stl);
        checks++;
        if (ack !== 1'b1 || rd !== model_read(16)) begin
            failures++;
            $display("FAIL wrap_count: ack=%0b dat=%0d, required ack=1 dat=%0d", ack, rd, model_read(16));
        end
    endtask

    initial begin
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_adr_i = '0;
        wb_if.wb_dat_i = '0;
        test_reset();
        test_burst();
        test_load(2, 1);
        test_burst();
        test_lock();
        test_invalid();
        test_load_concurrent();
        test_cyc_drop();
        test_reset_during_load();
        test_load(3, 2);
        test_random(200);
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
